// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of a single-port data memory.
//   Port 0 is the core load/store unit and port 1 is the debug/DMA loader.
//   Each grant runs IDLE -> ACCESS -> DONE, which gives one access every three cycles.
//   Every output comes from a register.
//   Optional feature: define DMEM_ARB_ADDR_CHECK_EN to enable address range checking.
//     When enabled, an out-of-range address skips the memory access.
//     It is then acknowledged with errN=1 and rdataN=0.
// Ports:
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   reqN_i, weN_i                request (held until ackN_o), 1=write 0=read
//   addrN_i, wdataN_i            word address and write data per requester
//   ackN_o, rdataN_o, errN_o     one-cycle completion pulse, read data, address error
//   mem_addr_o, mem_wdata_o      registered address and write data to memory
//   mem_we_o, mem_rd_o           registered write enable and read strobe
//   mem_rdata_i                  memory read data (combinational on mem_addr_o)
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 3,
  parameter bit PRIO_MODE  = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_rd_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  state_e state_q;
  logic win_q, rr_q, we_q, err_q;
  logic win_d, we_d, oor_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  // rr_q names the port that wins a tie; it points away from the port served last.
  assign win_d   = (req0_i & req1_i) ? (PRIO_MODE ? 1'b0 : rr_q) : req1_i;
  assign addr_d  = win_d ? addr1_i : addr0_i;
  assign wdata_d = win_d ? wdata1_i : wdata0_i;
  assign we_d    = win_d ? we1_i : we0_i;
`ifdef DMEM_ARB_ADDR_CHECK_EN
  assign oor_d = |addr_d[ADDR_W-1:DEPTH_LOG2];
`else
  assign oor_d = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      rr_q        <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      ack0_o      <= 1'b0;
      ack1_o      <= 1'b0;
      err0_o      <= 1'b0;
      err1_o      <= 1'b0;
      rdata0_o    <= '0;
      rdata1_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
      mem_rd_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req0_i | req1_i) begin
          win_q       <= win_d;
          we_q        <= we_d;
          err_q       <= oor_d;
          mem_addr_o  <= addr_d;
          mem_wdata_o <= wdata_d;
          // An out-of-range access leaves both strobes low, so memory is never touched.
          mem_we_o    <= we_d & ~oor_d;
          mem_rd_o    <= ~we_d & ~oor_d;
          state_q     <= ACCESS;
        end
        ACCESS: begin
          mem_we_o <= 1'b0;
          mem_rd_o <= 1'b0;
          ack0_o   <= ~win_q;
          ack1_o   <= win_q;
          err0_o   <= ~win_q & err_q;
          err1_o   <= win_q & err_q;
          // Writes leave rdata untouched unless they failed the address check.
          if ((~we_q | err_q) & ~win_q) rdata0_o <= err_q ? '0 : mem_rdata_i;
          if ((~we_q | err_q) & win_q) rdata1_o <= err_q ? '0 : mem_rdata_i;
          rr_q     <= ~win_q;
          state_q  <= DONE;
        end
        DONE: begin
          ack0_o  <= 1'b0;
          ack1_o  <= 1'b0;
          err0_o  <= 1'b0;
          err1_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench with round-robin (a) and fixed-priority (b) instances.
module tb_dmem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic ack0_a, ack1_a, err0_a, err1_a, we_a, rd_a;
  logic ack0_b, ack1_b, err0_b, err1_b, we_b, rd_b;
  logic [15:0] rdata0_a, rdata1_a, maddr_a, mwdata_a, mrdata_a;
  logic [15:0] rdata0_b, rdata1_b, maddr_b, mwdata_b, mrdata_b;
  logic [15:0] mem_a [8];
  logic [15:0] mem_b [8];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmem_arbiter #(.PRIO_MODE(1'b0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0_a), .ack1_o(ack1_a), .rdata0_o(rdata0_a), .rdata1_o(rdata1_a),
    .err0_o(err0_a), .err1_o(err1_a), .mem_addr_o(maddr_a), .mem_wdata_o(mwdata_a),
    .mem_we_o(we_a), .mem_rd_o(rd_a), .mem_rdata_i(mrdata_a));
  dmem_arbiter #(.PRIO_MODE(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0_b), .ack1_o(ack1_b), .rdata0_o(rdata0_b), .rdata1_o(rdata1_b),
    .err0_o(err0_b), .err1_o(err1_b), .mem_addr_o(maddr_b), .mem_wdata_o(mwdata_b),
    .mem_we_o(we_b), .mem_rd_o(rd_b), .mem_rdata_i(mrdata_b));
  assign mrdata_a = mem_a[maddr_a[2:0]];
  assign mrdata_b = mem_b[maddr_b[2:0]];
  always @(posedge clk) begin
    if (we_a) mem_a[maddr_a[2:0]] <= mwdata_a;
    if (we_b) mem_b[maddr_b[2:0]] <= mwdata_b;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_all;
    req0 = 0;
    req1 = 0;
  endtask
  initial begin
    tick;
    tick;
    check("rst_ack", {ack0_a, ack1_a, err0_a, err1_a}, 0);
    check("rst_strobe", {we_a, rd_a}, 0);
    check("rst_addr", maddr_a, 0);
    check("rst_wdata", mwdata_a, 0);
    check("rst_rdata", {rdata0_a, rdata1_a}, 0);
    rst_n = 1;
    // Preload word 5, then abort a second write to it with reset during ACCESS.
    req0 = 1; we0 = 1; addr0 = 16'd5; wdata0 = 16'hAAAA;
    tick; tick; idle_all; tick;
    check("pre5", mem_a[5], 16'hAAAA);
    req0 = 1; wdata0 = 16'h1111;
    tick;
    check("abort_we_pre", we_a, 1);
    #2 rst_n = 0;
    #1;
    check("abort_strobe", {we_a, rd_a, ack0_a, ack1_a}, 0);
    idle_all;
    tick;
    check("abort_word", mem_a[5], 16'hAAAA);
    rst_n = 1;
    tick;
    check("abort_noack", {ack0_a, ack1_a}, 0);
    // Port 0 writes 0xBEEF to address 3, then reads it back.
    req0 = 1; we0 = 1; addr0 = 16'd3; wdata0 = 16'hBEEF;
    tick;
    check("w3_we", we_a, 1);
    check("w3_addr", maddr_a, 3);
    check("w3_wdata", mwdata_a, 16'hBEEF);
    check("w3_noack", ack0_a, 0);
    tick;
    check("w3_ack", {ack0_a, ack1_a, we_a}, 3'b100);
    idle_all;
    tick;
    check("w3_ackdrop", ack0_a, 0);
    check("w3_mem", mem_a[3], 16'hBEEF);
    req0 = 1; we0 = 0;
    tick;
    check("r3_rd", {rd_a, we_a}, 2'b10);
    tick;
    check("r3_ack", {ack0_a, ack1_a}, 2'b10);
    check("r3_rdata", rdata0_a, 16'hBEEF);
    idle_all;
    tick;
    // Port 1 preloads word 7, then reads it back-to-back with req1 held high.
    req1 = 1; we1 = 1; addr1 = 16'd7; wdata1 = 16'h1234;
    tick; tick;
    check("w7_ack", {ack0_a, ack1_a}, 2'b01);
    idle_all;
    tick;
    req1 = 1; we1 = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      check($sformatf("b2b_ack1_%0d", i), ack1_a, (i % 3 == 1) ? 1 : 0);
      if (i % 3 == 1) check($sformatf("b2b_rdata_%0d", i), rdata1_a, 16'h1234);
      if (i == 4) idle_all;
    end
    // Both ports read at once: round-robin alternates, fixed priority starves port 1.
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'd3; addr1 = 16'd7;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (i % 3 == 1) begin
        check($sformatf("rr_grant_%0d", i), {ack0_a, ack1_a}, (i % 6 == 1) ? 2'b10 : 2'b01);
        check($sformatf("fp_grant_%0d", i), {ack0_b, ack1_b}, 2'b10);
      end
      if (i == 10) idle_all;
    end
    check("rr_rdata0", rdata0_a, 16'hBEEF);
    check("rr_rdata1", rdata1_a, 16'h1234);
    // req1 dropped one cycle after it was sampled: the transaction still completes.
    req1 = 1; we1 = 0; addr1 = 16'd7;
    tick;
    idle_all;
    tick;
    check("drop_ack", {ack0_a, ack1_a}, 2'b01);
    check("drop_rdata", rdata1_a, 16'h1234);
    tick;
    check("drop_once", ack1_a, 0);
    tick;
    check("drop_idle", {ack1_a, rd_a, we_a}, 0);
    // An out-of-range write to 0x0010.
    req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 16'h5555;
    tick;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    check("oor_we", we_a, 0);
    tick;
    check("oor_ack", {ack0_a, err0_a, ack1_a, err1_a}, 4'b1100);
    check("oor_rdata", rdata0_a, 0);
`else
    check("oor_we", we_a, 1);
    check("oor_addr", maddr_a, 16'h0010);
    tick;
    check("oor_ack", {ack0_a, err0_a, ack1_a, err1_a}, 4'b1000);
`endif
    idle_all;
    tick;
    check("oor_end", {ack0_a, err0_a}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
